// File: rtl/mult_seq_32.sv
// mult_seq_32: iterative 32x32 -> 64 shift-add multiplier (MIPS mult/multu).
// One product bit per cycle over 32 RUN cycles, start/busy/done handshake.
// Optional feature macro: MULT_SIGNED_EN. When defined, 'sign' selects signed
// operation through operand magnitudes and a final 64-bit negation. When
// undefined, every operation is unsigned and 'sign' is ignored.
module mult_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_last;
  logic [31:0] w_a_op;
  logic [31:0] w_b_op;
  logic [32:0] w_sum;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_result;
  logic        w_unused_acc0;

  // Start is only honoured when not iterating; RUN ignores it entirely.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_count == 5'd31);

`ifdef MULT_SIGNED_EN
  logic r_neg;
  logic w_neg_in;

  // Magnitudes in signed mode; 0x80000000 maps to itself and is used unsigned.
  always_comb begin
    w_a_op   = (sign && A[31]) ? (~A + 32'd1) : A;
    w_b_op   = (sign && B[31]) ? (~B + 32'd1) : B;
    w_neg_in = sign && (A[31] ^ B[31]);
  end

  // Sign flag captured with the operands for the final correction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= w_neg_in;
    end
  end

  // Two's complement of the 64-bit magnitude when the product is negative.
  always_comb begin
    w_result = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
  end
`else
  logic w_unused_sign;
  assign w_unused_sign = sign;

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    w_a_op   = A;
    w_b_op   = B;
    w_result = w_acc_nxt;
  end
`endif

  // One shift-add step: conditional add into the upper 33 bits, then shift right.
  always_comb begin
    w_sum     = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
    w_acc_nxt = {w_sum, r_acc[31:1]};
  end

  // Bit 0 of the accumulator is shifted out each step and never consumed.
  assign w_unused_acc0 = r_acc[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_count == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Iteration datapath: load on accept, step during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= w_a_op;
      r_mplier <= w_b_op;
      r_count  <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_count  <= r_count + 5'd1;
    end
  end

  // Result registers change only on the final RUN edge, so the downstream
  // zero detector sees a stable lo at every other time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_last) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mult_seq_32.sv
// tb_mult_seq_32: randomized and directed checks of mult_seq_32 against a
// plain-arithmetic product model. Follows MULT_SIGNED_EN like the design.
module tb_mult_seq_32;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mult_seq_32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference product: true 64-bit signed or unsigned product.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    if (s && SIGNED_BUILD) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'd0, a};
      eb = {32'd0, b};
    end
    return ea * eb;
  endfunction

  task automatic scramble_inputs();
    A    = $urandom;
    B    = $urandom;
    sign = 1'($urandom_range(1, 0));
  endtask

  // One complete operation from IDLE; optionally pulses start with new
  // operands at RUN cycle 10, which must be ignored.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input string tag, input bit inj);
    logic [63:0] exp;
    int          lat;
    int          busy_bad;
    exp      = ref_prod(a, b, s);
    lat      = -1;
    busy_bad = 0;
    A = a; B = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (inj && k == 10) begin
        start = 1'b1;
        scramble_inputs();
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_busy_low_run"}, 64'(busy_bad), 64'd0);
    check({tag, "_product"}, {hi, lo}, exp);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_lo_zero_det"}, 64'(|lo), 64'(exp[31:0] != 32'd0));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  // Reset asserted at RUN cycle 15 aborts the op without a done.
  task automatic do_abort(input logic [31:0] a, input logic [31:0] b);
    int dones;
    dones = 0;
    A = a; B = b; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 15; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
  endtask

  // Start held high from the first accept through the DONE cycle.
  task automatic do_b2b(input logic [31:0] a1, input logic [31:0] b1,
                        input logic [31:0] a2, input logic [31:0] b2);
    int lat1;
    int lat2;
    lat1 = -1;
    lat2 = -1;
    A = a1; B = b1; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = $urandom; B = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat1 = k;
        break;
      end
    end
    check("b2b_lat1", 64'(lat1), 64'd32);
    check("b2b_prod1", {hi, lo}, ref_prod(a1, b1, 1'b0));
    A = a2; B = b2; sign = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        check("b2b_busy_after_done", 64'(busy), 64'd1);
        scramble_inputs();
      end
      if (done) begin
        lat2 = k;
        break;
      end
    end
    check("b2b_gap", 64'(lat2), 64'd33);
    check("b2b_prod2", {hi, lo}, ref_prod(a2, b2, 1'b0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_done", 64'(done), 64'd0);

    do_op(32'd3, 32'd5, 1'b0, "u3x5", 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax", 1'b0);
    do_op(32'hFFFF_FFFE, 32'd3, 1'b1, "sneg2x3", 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, "sminsq", 1'b0);
    do_op(32'd7, 32'hFFFF_FFF9, 1'b1, "s7xneg7", 1'b0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "inj", 1'b1);
    do_op(32'd0, 32'h1234_5678, 1'b0, "zero", 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1, 0));
      do_op(ra, rb, rs, $sformatf("rnd%0d", i), 1'b0);
    end

    do_abort(32'hDEAD_BEEF, 32'h0000_1234);
    do_b2b(32'h0001_0003, 32'h0000_0101, $urandom, $urandom);
    do_op(32'hFFFF_FFFF, 32'd2, 1'b1, "post", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached without completion");
    $fatal(1);
  end

endmodule
